fp_convert_unit: RTL and testbench

- Parametrised multi-cycle int/float conversion unit for the PinKY floating-point datapath; sits beside the integer ALU in stage 3 and is started by the itof/ftoi instructions.
- Performs signed integer to float (itof) with selectable rounding, and float to signed integer (ftoi) with saturation.
- Uses a start/ready/done handshake with a fixed latency, so the pipeline stall logic can freeze for a known number of cycles.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/lead_zero_count.sv | 21 ++
 rtl/fp_convert_unit.sv | 198 +++++++++++++++++++
 tb/tb_fp_convert_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and float field helpers for the PinKY int/float conversion unit.
package fp_pkg;

  localparam logic [4:0] OP_ITOF = 5'b10010;
  localparam logic [4:0] OP_FTOI = 5'b10011;

  localparam int unsigned DEFAULT_BIAS = 127;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UNPACK = 2'd1;
  localparam logic [1:0] NORM   = 2'd2;
  localparam logic [1:0] ROUND  = 2'd3;

  // Layout is {sign, exp[exp_w], mant[mant_w]}, LSB-aligned in a 64-bit carrier.
  function automatic logic fld_sign(input logic [63:0] w, input int unsigned int_w);
    return w[int_w-1];
  endfunction

  function automatic logic [63:0] fld_exp(input logic [63:0] w, input int unsigned exp_w,
                                          input int unsigned mant_w);
    return (w >> mant_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fld_mant(input logic [63:0] w, input int unsigned mant_w);
    return w & ((64'd1 << mant_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fld_pack(input logic sign, input logic [63:0] exp,
                                           input logic [63:0] mant, input int unsigned exp_w,
                                           input int unsigned mant_w);
    logic [63:0] e_m;
    logic [63:0] m_m;
    e_m = exp & ((64'd1 << exp_w) - 64'd1);
    m_m = mant & ((64'd1 << mant_w) - 64'd1);
    return ({63'd0, sign} << (exp_w + mant_w)) | (e_m << mant_w) | m_m;
  endfunction

endpackage

// File: rtl/lead_zero_count.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module lead_zero_count #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(WIDTH):0]   count_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  // Scan upward so the most significant set bit writes last.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (data_i[i]) begin
        count_o = CW'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_convert_unit.sv
// Fixed-latency int<->float converter: itof with selectable rounding, ftoi with saturation.
module fp_convert_unit
  import fp_pkg::*;
#(
  parameter int unsigned INT_W       = 16,
  parameter int unsigned EXP_W       = 8,
  parameter int unsigned MANT_W      = 7,
  parameter int unsigned BIAS        = DEFAULT_BIAS,
  parameter logic        RND_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic             rnd_mode,
  input  logic [INT_W-1:0] operand,
  output logic             ready,
  output logic             done,
  output logic [INT_W-1:0] result,
  output logic             inexact,
  output logic             overflow,
  output logic             invalid
);

  localparam int unsigned LZW = $clog2(INT_W) + 1;
  localparam int unsigned XW  = EXP_W + 1;
  localparam logic [XW-1:0]    EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] STICKY_MASK = INT_W'((64'd1 << (INT_W - 2 - MANT_W)) - 64'd1);

  if (1 + EXP_W + MANT_W != INT_W) begin : g_bad_layout
    $fatal(1, "fp_convert_unit: 1+EXP_W+MANT_W must equal INT_W");
  end

  logic [1:0]        state_q, state_d;
  logic [4:0]        op_q;
  logic              rnd_q;
  logic [INT_W-1:0]  opnd_q;
  logic              sign_q;
  logic [INT_W-1:0]  mag_q;
  logic [EXP_W-1:0]  fexp_q;
  logic [MANT_W-1:0] fmant_q;
  logic [INT_W-1:0]  norm_q;
  logic [XW-1:0]     nexp_q;
  logic              zero_q;
  logic              done_q;
  logic [INT_W-1:0]  result_q, result_d;
  logic              inexact_q, inexact_d;
  logic              overflow_q, overflow_d;
  logic              invalid_q, invalid_d;
  logic [LZW-1:0]    lz_cnt;

  lead_zero_count #(
    .WIDTH(INT_W)
  ) u_lzc (
    .data_i (mag_q),
    .count_o(lz_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = UNPACK;
      UNPACK:  state_d = NORM;
      NORM:    state_d = ROUND;
      default: state_d = IDLE;
    endcase
  end

  // itof rounding terms
  logic [MANT_W-1:0] mant_t;
  logic              g_bit, s_bit, inc;
  logic [MANT_W:0]   mant_sum;
  logic [XW-1:0]     exp_r;
  // ftoi shift terms
  logic [XW-1:0]     fexp_x, e_x, lsh, rsh;
  logic [INT_W-1:0]  sig, mag_f, lost;

  always_comb begin
    mant_t   = norm_q[INT_W-2 -: MANT_W];
    g_bit    = norm_q[INT_W-2-MANT_W];
    s_bit    = |(norm_q & STICKY_MASK);
    inc      = rnd_q & g_bit & (s_bit | mant_t[0]);
    mant_sum = {1'b0, mant_t} + {{MANT_W{1'b0}}, inc};
    exp_r    = nexp_q + {{EXP_W{1'b0}}, mant_sum[MANT_W]};

    fexp_x = {1'b0, fexp_q};
    e_x    = fexp_x - XW'(BIAS);
    lsh    = e_x - XW'(MANT_W);
    rsh    = XW'(MANT_W) - e_x;
    sig    = INT_W'({1'b1, fmant_q});
    mag_f  = (e_x >= XW'(MANT_W)) ? (sig << lsh) : (sig >> rsh);
    lost   = sig & ((INT_W'(1) << rsh) - INT_W'(1));

    result_d   = '0;
    inexact_d  = 1'b0;
    overflow_d = 1'b0;
    invalid_d  = 1'b0;

    case (op_q)
      OP_ITOF: begin
        if (!zero_q) begin
          inexact_d = g_bit | s_bit;
          if (exp_r >= EXP_MAX) begin
            result_d   = INT_W'(fld_pack(sign_q, 64'(EXP_MAX), 64'd0, EXP_W, MANT_W));
            overflow_d = 1'b1;
          end else begin
            result_d = INT_W'(fld_pack(sign_q, 64'(exp_r), 64'(mant_sum), EXP_W, MANT_W));
          end
        end
      end
      OP_FTOI: begin
        if (fexp_q == '0) begin
          inexact_d = |fmant_q;
        end else if (&fexp_q && |fmant_q) begin
          invalid_d = 1'b1;
        end else if (&fexp_q) begin
          result_d   = sign_q ? INT_MIN : INT_MAX;
          overflow_d = 1'b1;
        end else if (fexp_x < XW'(BIAS)) begin
          inexact_d = 1'b1;
        end else if (e_x >= XW'(INT_W - 1)) begin
          // -2^(INT_W-1) is the one representable value at this magnitude
          if (sign_q && e_x == XW'(INT_W - 1) && fmant_q == '0) begin
            result_d = INT_MIN;
          end else begin
            result_d   = sign_q ? INT_MIN : INT_MAX;
            overflow_d = 1'b1;
          end
        end else begin
          result_d  = sign_q ? (~mag_f + INT_W'(1)) : mag_f;
          inexact_d = (e_x < XW'(MANT_W)) && (|lost);
        end
      end
      default: invalid_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rnd_q      <= RND_DEFAULT;
      opnd_q     <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      fexp_q     <= '0;
      fmant_q    <= '0;
      norm_q     <= '0;
      nexp_q     <= '0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            rnd_q  <= rnd_mode;
            opnd_q <= operand;
          end
        end
        UNPACK: begin
          sign_q  <= fld_sign(64'(opnd_q), INT_W);
          mag_q   <= opnd_q[INT_W-1] ? (~opnd_q + INT_W'(1)) : opnd_q;
          fexp_q  <= EXP_W'(fld_exp(64'(opnd_q), EXP_W, MANT_W));
          fmant_q <= MANT_W'(fld_mant(64'(opnd_q), MANT_W));
        end
        NORM: begin
          norm_q <= mag_q << lz_cnt;
          nexp_q <= XW'(BIAS) + XW'(INT_W - 1) - XW'(lz_cnt);
          zero_q <= (lz_cnt == LZW'(INT_W));
        end
        default: begin
          result_q   <= result_d;
          inexact_q  <= inexact_d;
          overflow_q <= overflow_d;
          invalid_q  <= invalid_d;
          done_q     <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign inexact  = inexact_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_fp_convert_unit.sv
// Directed scoreboard bench for fp_convert_unit at default parameters.
module tb_fp_convert_unit;

  localparam logic [4:0] ITOF = 5'b10010;
  localparam logic [4:0] FTOI = 5'b10011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  op;
  logic        rnd_mode;
  logic [15:0] operand;
  logic        ready, done, inexact, overflow, invalid;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;
  int dones;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flg;  // {inexact, overflow, invalid}
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  fp_convert_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rnd_mode(rnd_mode),
    .operand (operand),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .inexact (inexact),
    .overflow(overflow),
    .invalid (invalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/ready"}, 32'(ready), 32'd1);
    chk({tag, "/done"}, 32'(done), 32'd0);
    chk({tag, "/result"}, 32'(result), 32'd0);
    chk({tag, "/flags"}, 32'({inexact, overflow, invalid}), 32'd0);
  endtask

  task automatic launch(input bit now, input logic [4:0] o, input logic r, input logic [15:0] a,
                        input logic [15:0] res, input logic [2:0] flg, input string tag);
    exp_t e;
    if (!now) @(negedge clk);
    start    = 1'b1;
    op       = o;
    rnd_mode = r;
    operand  = a;
    e.res = res;
    e.flg = flg;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_out();
    exp_t e;
    chk("scoreboard/nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "/result"}, 32'(result), 32'(e.res));
      chk({e.tag, "/flags"}, 32'({inexact, overflow, invalid}), 32'(e.flg));
    end
  endtask

  // Called at the negedge just after the accepting edge; done is due 3 edges later.
  task automatic expect_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/latency"}, 32'(k), 32'd3);
    chk({tag, "/ready_at_done"}, 32'(ready), 32'd1);
    if (done === 1'b1) check_out();
    else void'(sb_q.pop_front());
  endtask

  task automatic op_test(input logic [4:0] o, input logic r, input logic [15:0] a,
                         input logic [15:0] res, input logic [2:0] flg, input string tag);
    launch(1'b0, o, r, a, res, flg, tag);
    chk({tag, "/busy"}, 32'(ready), 32'd0);
    expect_done(tag);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    op       = 5'd0;
    rnd_mode = 1'b0;
    operand  = 16'd0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;

    op_test(ITOF, 1'b1, 16'h0001, 16'h3F80, 3'b000, "itof_1");
    @(negedge clk);
    chk("itof_1/pulse", 32'(done), 32'd0);
    op_test(ITOF, 1'b1, 16'h0003, 16'h4040, 3'b000, "itof_3");
    op_test(ITOF, 1'b1, 16'h0103, 16'h4382, 3'b100, "itof_259_rne");
    op_test(ITOF, 1'b0, 16'h0103, 16'h4381, 3'b100, "itof_259_trunc");
    op_test(ITOF, 1'b1, 16'h0101, 16'h4380, 3'b100, "itof_257_tie");
    op_test(ITOF, 1'b1, 16'h7FFF, 16'h4700, 3'b100, "itof_7fff_carry");
    op_test(ITOF, 1'b1, 16'h8000, 16'hC700, 3'b000, "itof_min");
    op_test(ITOF, 1'b1, 16'h0000, 16'h0000, 3'b000, "itof_zero");
    op_test(FTOI, 1'b1, 16'hC020, 16'hFFFE, 3'b100, "ftoi_m2p5");
    op_test(FTOI, 1'b0, 16'h4040, 16'h0003, 3'b000, "ftoi_3");
    op_test(FTOI, 1'b0, 16'h4780, 16'h7FFF, 3'b010, "ftoi_sat_pos");
    op_test(FTOI, 1'b0, 16'hC780, 16'h8000, 3'b010, "ftoi_sat_neg");
    op_test(FTOI, 1'b0, 16'hC700, 16'h8000, 3'b000, "ftoi_min_exact");
    op_test(FTOI, 1'b0, 16'h7F81, 16'h0000, 3'b001, "ftoi_nan");
    op_test(FTOI, 1'b0, 16'h7F80, 16'h7FFF, 3'b010, "ftoi_inf");
    op_test(FTOI, 1'b0, 16'h3F00, 16'h0000, 3'b100, "ftoi_half");
    op_test(FTOI, 1'b0, 16'h0001, 16'h0000, 3'b100, "ftoi_denorm");
    op_test(5'b00000, 1'b0, 16'h1234, 16'h0000, 3'b001, "bad_op");

    // Start in the done cycle is accepted immediately.
    launch(1'b0, ITOF, 1'b1, 16'h0001, 16'h3F80, 3'b000, "b2b_a");
    expect_done("b2b_a");
    launch(1'b1, FTOI, 1'b0, 16'h4040, 16'h0003, 3'b000, "b2b_b");
    expect_done("b2b_b");

    // Start held for 5 cycles across a busy window: only one more op is taken.
    launch(1'b0, FTOI, 1'b0, 16'h4040, 16'h0003, 3'b000, "hold_a");
    start    = 1'b1;
    op       = ITOF;
    rnd_mode = 1'b1;
    operand  = 16'h0003;
    begin
      exp_t e;
      e.res = 16'h4040;
      e.flg = 3'b000;
      e.tag = "hold_b";
      sb_q.push_back(e);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        check_out();
      end
    end
    chk("hold/dones", 32'(dones), 32'd2);
    chk("hold/queue_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset in NORM abandons the operation.
    launch(1'b0, ITOF, 1'b1, 16'h0003, 16'h4040, 3'b000, "rst_op");
    void'(sb_q.pop_back());
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_idle("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("rst/no_done", 32'(dones), 32'd0);
    op_test(ITOF, 1'b1, 16'hFFFF, 16'hBF80, 3'b000, "itof_m1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
